prog_data_mem: RTL

//  Parametrised program/data memory for the teaching CPU. Owns the program store (ROM region,

---
 rtl/prog_data_mem_pkg.sv | 25 ++
 rtl/prog_data_mem_if.sv | 25 ++
 rtl/prog_data_mem_key_edge_det.sv | 26 ++
 rtl/prog_data_mem.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/prog_data_mem_pkg.sv
// Shared definitions for the program/data memory block:
// cpustate encodings, default widths and the RAM index helper.
package mem_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 16;
    localparam int ROM_AW = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_IN    = 2'b01,
        ST_CHECK = 2'b10,
        ST_RUN   = 2'b11
    } cpustate_e;

    // RAM entry addressed by a CPU address: the bits above
    // the program region select the word.
    function automatic logic [31:0] ram_index(
        input logic [31:0] addr,
        input int unsigned rom_aw = ROM_AW
    );
        return addr >> rom_aw;
    endfunction

endpackage

// File: rtl/prog_data_mem_if.sv
// CPU-side bus of the program/data memory.
// master (CPU): cpustate, addr, data_in, read, write
// slave (memory): data_out, rd_valid
interface prog_data_mem_if #(
    parameter int DATA_W = mem_pkg::DATA_W,
    parameter int ADDR_W = mem_pkg::ADDR_W
);
    logic [1:0]        cpustate;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;

    modport master (
        output cpustate, addr, data_in, read, write,
        input  data_out, rd_valid
    );

    modport slave (
        input  cpustate, addr, data_in, read, write,
        output data_out, rd_valid
    );
endinterface

// File: rtl/prog_data_mem_key_edge_det.sv
// Board button conditioner: 2-flop synchroniser plus a
// one-cycle pulse on each press of an active-low key.
// Ports: clk, reset (sync, active-high), key_n (raw), press.
module key_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);
    logic r_s1;
    logic r_s2;

    // Idle level of the key is high, so reset to 1 to
    // avoid a phantom press after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else begin
            r_s1 <= key_n;
            r_s2 <= r_s1;
        end
    end

    assign press = ~r_s1 & r_s2;
endmodule

// File: rtl/prog_data_mem.sv
// Program/data memory of the teaching CPU: program store loaded
// from switches (IN), stepped (CHECK), CPU RAM access (RUN).
// Ports: clk, reset (sync, active-high), key_n, sw, bus (slave),
//   check_out, ptr, full, err (sticky illegal access).
// Build option: define PROG_WR_EN to let RUN writes modify
//   the program region instead of flagging an error.
module prog_data_mem #(
    parameter int DATA_W    = mem_pkg::DATA_W,
    parameter int ADDR_W    = mem_pkg::ADDR_W,
    parameter int ROM_AW    = mem_pkg::ROM_AW,
    parameter int RAM_DEPTH = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_n,
    input  logic [DATA_W-1:0] sw,
    prog_data_mem_if.slave    bus,
    output logic [DATA_W-1:0] check_out,
    output logic [ROM_AW-1:0] ptr,
    output logic              full,
    output logic              err
);
    import mem_pkg::*;

    localparam int ROM_DEPTH = 2 ** ROM_AW;
    localparam int RAM_IW    = $clog2(RAM_DEPTH);
    localparam logic [ROM_AW-1:0] PTR_LAST = ROM_AW'(ROM_DEPTH - 1);

`ifdef PROG_WR_EN
    localparam bit PROG_WR = 1'b1;
`else
    localparam bit PROG_WR = 1'b0;
`endif

    logic [DATA_W-1:0] r_prog [ROM_DEPTH];
    logic [DATA_W-1:0] r_ram  [RAM_DEPTH];

    cpustate_e         w_state;
    cpustate_e         r_prev_state;
    logic [ROM_AW-1:0] r_ptr;
    logic              r_full;
    logic              r_err;
    logic [DATA_W-1:0] r_data;
    logic              r_rd_valid;

    logic              w_press;
    logic              w_entry;
    logic              w_run;
    logic              w_load;
    logic              w_step;
    logic              w_rom_hit;
    logic [ROM_AW-1:0] w_rom_idx;
    logic [31:0]       w_ram_idx32;
    logic              w_ram_ok;
    logic [RAM_IW-1:0] w_ram_idx;
    logic              w_bad_rd;
    logic              w_bad_wr;
    logic              w_prog_we;
    logic [ROM_AW-1:0] w_prog_wa;
    logic [DATA_W-1:0] w_prog_wd;
    logic              w_ram_we;
    logic [DATA_W-1:0] w_rd_word;

    key_edge_det u_key (
        .clk   (clk),
        .reset (reset),
        .key_n (key_n),
        .press (w_press)
    );

    assign w_state = cpustate_e'(bus.cpustate);
    assign w_run   = (w_state == ST_RUN);

    // Entering IN or CHECK restarts the pointer; a press
    // landing on the same edge is swallowed.
    assign w_entry = (w_state != r_prev_state) &&
                     (w_state == ST_IN || w_state == ST_CHECK);

    assign w_load = w_press & ~w_entry & ~r_full &
                    (w_state == ST_IN);
    assign w_step = w_press & ~w_entry &
                    (w_state == ST_CHECK);

    // Address decode: zero upper bits select the program
    // region, anything else indexes the RAM.
    assign w_rom_hit   = (bus.addr[ADDR_W-1:ROM_AW] == '0);
    assign w_rom_idx   = bus.addr[ROM_AW-1:0];
    assign w_ram_idx32 = ram_index(32'(bus.addr), ROM_AW);
    assign w_ram_ok    = (w_ram_idx32 < 32'(RAM_DEPTH));
    assign w_ram_idx   = w_ram_idx32[RAM_IW-1:0];

    assign w_bad_rd = w_run & bus.read &
                      ~w_rom_hit & ~w_ram_ok;
    assign w_bad_wr = w_run & bus.write &
                      (w_rom_hit ? ~PROG_WR : ~w_ram_ok);

    // IN loads and RUN self-modifying writes share the
    // program write port; they never coincide in one mode.
    assign w_prog_we = ~reset & (w_load |
                       (w_run & bus.write & w_rom_hit & PROG_WR));
    assign w_prog_wa = w_load ? r_ptr : w_rom_idx;
    assign w_prog_wd = w_load ? sw : bus.data_in;

    assign w_ram_we = ~reset & w_run & bus.write &
                      ~w_rom_hit & w_ram_ok;

    always_comb begin
        w_rd_word = '0;
        if (w_rom_hit) begin
            w_rd_word = r_prog[w_rom_idx];
        end else if (w_ram_ok) begin
            w_rd_word = r_ram[w_ram_idx];
        end
    end

    // Storage arrays are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_prog_we) begin
            r_prog[w_prog_wa] <= w_prog_wd;
        end
        if (w_ram_we) begin
            r_ram[w_ram_idx] <= bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_state <= ST_IDLE;
            r_ptr        <= '0;
            r_full       <= 1'b0;
        end else begin
            r_prev_state <= w_state;
            if (w_entry) begin
                r_ptr <= '0;
                if (w_state == ST_IN) begin
                    r_full <= 1'b0;
                end
            end else if (w_load) begin
                // Last slot wraps the pointer back to 0.
                r_ptr <= r_ptr + 1'b1;
                if (r_ptr == PTR_LAST) begin
                    r_full <= 1'b1;
                end
            end else if (w_step) begin
                r_ptr <= r_ptr + 1'b1;
            end
        end
    end

    // Registered read port; old word is returned when a
    // write hits the same location on the same edge.
    always_ff @(posedge clk) begin
        if (reset || !w_run) begin
            r_data     <= '0;
            r_rd_valid <= 1'b0;
        end else if (bus.read) begin
            r_data     <= w_rd_word;
            r_rd_valid <= 1'b1;
        end else begin
            r_rd_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_bad_rd || w_bad_wr) begin
            r_err <= 1'b1;
        end
    end

    assign bus.data_out = w_run ? r_data : '0;
    assign bus.rd_valid = w_run & r_rd_valid;

    assign check_out = (w_state == ST_CHECK) ?
                       r_prog[r_ptr] : '0;
    assign ptr  = r_ptr;
    assign full = r_full;
    assign err  = r_err;
endmodule
